// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared constants and helpers for the single-cycle RV32I core.
//   Opcodes, funct3/funct7 encodings, the ALU operation enum and the
//   combinational helper functions (ALU operation select, ALU datapath,
//   branch comparison) used by the top-level decoder.
package rv32i_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned IMEM_WORDS = 256;
   localparam int unsigned DMEM_WORDS = 256;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // funct3 for ALU operations
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct3 for branches
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct3 for word loads/stores (only width supported)
   localparam logic [2:0] F3_WORD = 3'b010;

   // funct7 selecting sub/sra; only instr[30] differs from the base encoding
   localparam logic [6:0] F7_ALT = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_e;

   // The alternate bit selects sub only for register-register forms; for
   // addi it is just an immediate bit. For shifts-right it selects sra/srai.
   function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                          input logic       alt,
                                          input logic       is_reg);
      alu_op_e op;
      case (f3)
         F3_ADD_SUB: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         default:    op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [XLEN-1:0] alu_exec(input alu_op_e         op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
         ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: r = {31'd0, a < b};
         default:  r = '0;
      endcase
      return r;
   endfunction

   function automatic logic branch_taken(input logic [2:0]      f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
      logic t;
      case (f3)
         F3_BEQ:  t = (a == b);
         F3_BNE:  t = (a != b);
         F3_BLT:  t = ($signed(a) <  $signed(b));
         F3_BGE:  t = ($signed(a) >= $signed(b));
         F3_BLTU: t = (a <  b);
         F3_BGEU: t = (a >= b);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/top_dmem.sv
// top_dmem -- 256 x 32-bit data memory, combinational read, write on the
//   rising clock edge. A same-cycle read of the word being written returns
//   the old contents.
//   i_clk   : clock
//   i_we    : word write enable
//   i_addr  : byte address (only bits [9:2] select the word)
//   i_wdata : store data
//   o_rdata : load data
module top_dmem
   import rv32i_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_rdata
);

   logic [XLEN-1:0] data_memory [0:DMEM_WORDS-1];

   logic w_unused_addr_bits;
   assign w_unused_addr_bits = ^{i_addr[31:10], i_addr[1:0]};

   // NOTE: memory arrays carry no reset; contents survive n_rst and the
   // array maps onto plain RAM instead of a wall of resettable flops.
   always_ff @(posedge i_clk) begin
      if (i_we) data_memory[i_addr[9:2]] <= i_wdata;
   end

   assign o_rdata = data_memory[i_addr[9:2]];

endmodule

// File: rtl/top_imem.sv
// top_imem -- 256 x 32-bit instruction memory, combinational read.
//   i_addr  : byte address (only bits [9:2] select the word)
//   o_rdata : instruction word
// Contents are loaded externally through the instruction_memory array.
module top_imem
   import rv32i_pkg::*;
(
   input  logic [XLEN-1:0] i_addr,
   output logic [XLEN-1:0] o_rdata
);

   logic [XLEN-1:0] instruction_memory [0:IMEM_WORDS-1];

   // Addresses alias every 1 KiB and byte offsets are ignored.
   logic w_unused_addr_bits;
   assign w_unused_addr_bits = ^{i_addr[31:10], i_addr[1:0]};

   assign o_rdata = instruction_memory[i_addr[9:2]];

endmodule

// File: rtl/top_rf.sv
// top_rf -- 32 x 32-bit register file, two combinational read ports and
//   one write port on the rising clock edge; x0 is hard-wired to zero.
//   i_clk, i_n_rst        : clock, asynchronous active-low reset (clears all)
//   i_raddr1/o_rdata1     : read port 1
//   i_raddr2/o_rdata2     : read port 2
//   i_we/i_waddr/i_wdata  : write port
// Reads of the register being written return the pre-edge value.
module top_rf
   import rv32i_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_n_rst,
   input  logic [4:0]      i_raddr1,
   input  logic [4:0]      i_raddr2,
   output logic [XLEN-1:0] o_rdata1,
   output logic [XLEN-1:0] o_rdata2,
   input  logic            i_we,
   input  logic [4:0]      i_waddr,
   input  logic [XLEN-1:0] i_wdata
);

   logic [XLEN-1:0] RF [0:31];

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         for (int i = 0; i < 32; i++) RF[i] <= '0;
      end else if (i_we && (i_waddr != 5'd0)) begin
         RF[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : RF[i_raddr1];
   assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : RF[i_raddr2];

endmodule

// File: rtl/top.sv
// top -- single-cycle RV32I core (integer base without byte/half memory ops,
//   fence or system instructions). One instruction is fetched, executed and
//   retired on every rising clk edge.
//   clk   : system clock
//   n_rst : asynchronous active-low reset (PC and register file cleared)
// Program and data live in DUT_instr / DUT_Data; architectural state is
// observed through PC, instr and DUT_RF.
module top
   import rv32i_pkg::*;
(
   input logic clk,
   input logic n_rst
);

   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] instr;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [XLEN-1:0] w_rs1_val, w_rs2_val;
   logic [XLEN-1:0] w_pc_plus4, w_pc_next;
   logic [XLEN-1:0] w_rd_data;
   logic            w_rf_we;
   logic [XLEN-1:0] w_mem_addr, w_mem_rdata;
   logic            w_mem_we_raw, w_mem_we;

   top_imem DUT_instr (
      .i_addr  (PC),
      .o_rdata (instr)
   );

   top_rf DUT_RF (
      .i_clk    (clk),
      .i_n_rst  (n_rst),
      .i_raddr1 (instr[19:15]),
      .i_raddr2 (instr[24:20]),
      .o_rdata1 (w_rs1_val),
      .o_rdata2 (w_rs2_val),
      .i_we     (w_rf_we),
      .i_waddr  (instr[11:7]),
      .i_wdata  (w_rd_data)
   );

   top_dmem DUT_Data (
      .i_clk   (clk),
      .i_we    (w_mem_we),
      .i_addr  (w_mem_addr),
      .i_wdata (w_rs2_val),
      .o_rdata (w_mem_rdata)
   );

   assign w_opcode   = instr[6:0];
   assign w_funct3   = instr[14:12];
   assign w_pc_plus4 = PC + 32'd4;

   assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
   assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign w_imm_u = {instr[31:12], 12'd0};
   assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // A store fetched while reset is held must not reach the memory, which
   // has no reset of its own.
   assign w_mem_we = w_mem_we_raw & n_rst;

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      w_rf_we      = 1'b0;
      w_rd_data    = '0;
      w_mem_we_raw = 1'b0;
      w_mem_addr   = w_rs1_val + w_imm_i;
      w_pc_next    = w_pc_plus4;
      case (w_opcode)
         OP_REG: begin
            w_rf_we   = 1'b1;
            w_rd_data = alu_exec(alu_decode(w_funct3, instr[30], 1'b1), w_rs1_val, w_rs2_val);
         end
         OP_IMM: begin
            w_rf_we   = 1'b1;
            w_rd_data = alu_exec(alu_decode(w_funct3, instr[30], 1'b0), w_rs1_val, w_imm_i);
         end
         OP_LOAD: begin
            if (w_funct3 == F3_WORD) begin
               w_rf_we   = 1'b1;
               w_rd_data = w_mem_rdata;
            end
         end
         OP_STORE: begin
            w_mem_addr   = w_rs1_val + w_imm_s;
            w_mem_we_raw = (w_funct3 == F3_WORD);
         end
         OP_BRANCH: begin
            if (branch_taken(w_funct3, w_rs1_val, w_rs2_val)) w_pc_next = PC + w_imm_b;
         end
         OP_JAL: begin
            w_rf_we   = 1'b1;
            w_rd_data = w_pc_plus4;
            w_pc_next = PC + w_imm_j;
         end
         OP_JALR: begin
            // rs1 is sampled combinationally before the edge, so rd == rs1 is safe.
            w_rf_we   = 1'b1;
            w_rd_data = w_pc_plus4;
            w_pc_next = (w_rs1_val + w_imm_i) & 32'hFFFF_FFFE;
         end
         OP_LUI: begin
            w_rf_we   = 1'b1;
            w_rd_data = w_imm_u;
         end
         OP_AUIPC: begin
            w_rf_we   = 1'b1;
            w_rd_data = PC + w_imm_u;
         end
         default: ;  // unrecognised opcode: plain PC + 4
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) PC <= '0;
      else        PC <= w_pc_next;
   end

endmodule

// File: tb/tb_top.sv
// tb_top -- directed self-checking bench for the single-cycle RV32I core.
//   Programs are written straight into DUT_instr.instruction_memory while
//   reset is held; after release a fixed number of edges is run and the
//   register file, data memory and PC are compared against hand-computed
//   values.
module tb_top;

   logic clk   = 1'b0;
   logic n_rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   top dut (
      .clk   (clk),
      .n_rst (n_rst)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] O_IMM = 7'h13, O_REG = 7'h33, O_LOAD = 7'h03, O_STORE = 7'h23;
   localparam logic [6:0] O_BR = 7'h63, O_JAL = 7'h6F, O_JALR = 7'h67, O_LUI = 7'h37, O_AUIPC = 7'h17;

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, O_REG};
   endfunction

   function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return i_t(imm, rs1, 3'd0, rd, O_IMM);
   endfunction

   function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], O_STORE};
   endfunction

   function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], O_BR};
   endfunction

   function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd,
                                       input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, O_JAL};
   endfunction

   // ---------------- helpers ----------------
   function automatic logic [31:0] xr(input int idx);
      return dut.DUT_RF.RF[idx];
   endfunction

   function automatic logic [31:0] dm(input int idx);
      return dut.DUT_Data.data_memory[idx];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic put(input int idx, input logic [31:0] w);
      dut.DUT_instr.instruction_memory[idx] = w;
   endtask

   // Hold reset and fill the instruction memory with all-zero words (NOPs).
   task automatic start_prog();
      n_rst = 1'b0;
      for (int i = 0; i < 256; i++) put(i, 32'h0000_0000);
   endtask

   // Release reset on a falling edge, then run exactly n rising edges.
   task automatic run(input int edges);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (edges) @(posedge clk);
      #1;
   endtask

   initial begin
      #2;

      // ---- arithmetic basics + reset state ----
      start_prog();
      put(0, addi(5'd1, 5'd0, 12'd10));
      put(1, addi(5'd2, 5'd0, 12'd5));
      put(2, r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
      put(3, r_t(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
      @(negedge clk);
      check("rst_pc", dut.PC, 32'h0);
      for (int i = 0; i < 32; i++) check($sformatf("rst_x%0d", i), xr(i), 32'h0);
      check("rst_instr", dut.instr, addi(5'd1, 5'd0, 12'd10));
      run(7);
      check("add_x1", xr(1), 32'd10);
      check("add_x2", xr(2), 32'd5);
      check("add_x3", xr(3), 32'd15);
      check("sub_x4", xr(4), 32'd5);
      check("nop_pc", dut.PC, 32'd28);

      // ---- word load/store, address aliasing ----
      start_prog();
      put(0, addi(5'd1, 5'd0, 12'd100));
      put(1, s_t(12'd0, 5'd1, 5'd0));
      put(2, i_t(12'd0, 5'd0, 3'b010, 5'd2, O_LOAD));
      put(3, addi(5'd3, 5'd2, 12'd1));
      put(4, addi(5'd4, 5'd0, 12'hFFF));
      put(5, s_t(12'd1028, 5'd4, 5'd0));
      put(6, i_t(12'd4, 5'd0, 3'b010, 5'd5, O_LOAD));
      put(7, i_t(12'd7, 5'd0, 3'b010, 5'd6, O_LOAD));
      run(8);
      check("sw_dm0", dm(0), 32'd100);
      check("lw_x2", xr(2), 32'd100);
      check("lw_use_x3", xr(3), 32'd101);
      check("sw_alias_dm1", dm(1), 32'hFFFF_FFFF);
      check("lw_x5", xr(5), 32'hFFFF_FFFF);
      check("lw_lowbits_x6", xr(6), 32'hFFFF_FFFF);

      // ---- ALU coverage ----
      start_prog();
      put(0,  addi(5'd1, 5'd0, 12'hFF8));
      put(1,  addi(5'd2, 5'd0, 12'd3));
      put(2,  r_t(7'h00, 5'd2, 5'd1, 3'd1, 5'd3));
      put(3,  r_t(7'h00, 5'd2, 5'd1, 3'd5, 5'd4));
      put(4,  r_t(7'h20, 5'd2, 5'd1, 3'd5, 5'd5));
      put(5,  r_t(7'h00, 5'd2, 5'd1, 3'd2, 5'd6));
      put(6,  r_t(7'h00, 5'd2, 5'd1, 3'd3, 5'd7));
      put(7,  r_t(7'h00, 5'd2, 5'd1, 3'd4, 5'd8));
      put(8,  r_t(7'h00, 5'd2, 5'd1, 3'd6, 5'd9));
      put(9,  r_t(7'h00, 5'd2, 5'd1, 3'd7, 5'd10));
      put(10, i_t(12'h00F, 5'd1, 3'd7, 5'd11, O_IMM));
      put(11, i_t(12'hFF0, 5'd2, 3'd6, 5'd12, O_IMM));
      put(12, i_t(12'hFFF, 5'd1, 3'd4, 5'd13, O_IMM));
      put(13, i_t(12'hFF9, 5'd1, 3'd2, 5'd14, O_IMM));
      put(14, i_t(12'hFFF, 5'd2, 3'd3, 5'd15, O_IMM));
      put(15, i_t(12'h01F, 5'd2, 3'd1, 5'd16, O_IMM));
      put(16, i_t(12'h01C, 5'd1, 3'd5, 5'd17, O_IMM));
      put(17, i_t(12'h401, 5'd1, 3'd5, 5'd18, O_IMM));
      put(18, addi(5'd19, 5'd0, 12'd33));
      put(19, r_t(7'h00, 5'd19, 5'd2, 3'd1, 5'd20));
      put(20, u_t(20'h80000, 5'd21, O_LUI));
      put(21, r_t(7'h00, 5'd21, 5'd21, 3'd0, 5'd22));
      put(22, addi(5'd23, 5'd0, 12'h400));
      put(23, r_t(7'h00, 5'd1, 5'd2, 3'd3, 5'd24));
      run(24);
      check("sll", xr(3), 32'hFFFF_FFC0);
      check("srl", xr(4), 32'h1FFF_FFFF);
      check("sra", xr(5), 32'hFFFF_FFFF);
      check("slt", xr(6), 32'd1);
      check("sltu_f", xr(7), 32'd0);
      check("xor", xr(8), 32'hFFFF_FFFB);
      check("or", xr(9), 32'hFFFF_FFFB);
      check("and", xr(10), 32'h0);
      check("andi", xr(11), 32'd8);
      check("ori", xr(12), 32'hFFFF_FFF3);
      check("xori", xr(13), 32'd7);
      check("slti", xr(14), 32'd1);
      check("sltiu", xr(15), 32'd1);
      check("slli", xr(16), 32'h8000_0000);
      check("srli", xr(17), 32'h0000_000F);
      check("srai", xr(18), 32'hFFFF_FFFC);
      check("sll_shamt5", xr(20), 32'd6);
      check("add_wrap", xr(22), 32'h0);
      check("addi_bit30", xr(23), 32'h0000_0400);
      check("sltu_t", xr(24), 32'd1);

      // ---- branch variants ----
      start_prog();
      put(0,  addi(5'd1, 5'd0, 12'hFFF));
      put(1,  addi(5'd2, 5'd0, 12'd1));
      put(2,  b_t(13'd8, 5'd2, 5'd1, 3'd4));
      put(3,  addi(5'd3, 5'd0, 12'd1));
      put(4,  b_t(13'd8, 5'd2, 5'd1, 3'd6));
      put(5,  addi(5'd4, 5'd0, 12'd1));
      put(6,  b_t(13'd8, 5'd1, 5'd2, 3'd5));
      put(7,  addi(5'd5, 5'd0, 12'd1));
      put(8,  b_t(13'd8, 5'd1, 5'd2, 3'd7));
      put(9,  addi(5'd6, 5'd0, 12'd1));
      put(10, b_t(13'd8, 5'd1, 5'd1, 3'd0));
      put(11, addi(5'd7, 5'd0, 12'd1));
      run(9);
      check("blt_taken", xr(3), 32'd0);
      check("bltu_not", xr(4), 32'd1);
      check("bge_taken", xr(5), 32'd0);
      check("bgeu_not", xr(6), 32'd1);
      check("beq_taken", xr(7), 32'd0);
      check("br_pc", dut.PC, 32'd48);

      // ---- counted loop with backward bne ----
      start_prog();
      put(0, addi(5'd1, 5'd0, 12'd0));
      put(1, addi(5'd2, 5'd0, 12'd5));
      put(2, addi(5'd1, 5'd1, 12'd1));
      put(3, b_t(13'h1FFC, 5'd2, 5'd1, 3'd1));
      run(19);
      check("loop_x1", xr(1), 32'd5);
      check("loop_pc", dut.PC, 32'd44);

      // ---- jal ----
      start_prog();
      put(0, j_t(21'd8, 5'd1));
      put(1, addi(5'd2, 5'd0, 12'd1));
      put(2, addi(5'd3, 5'd0, 12'd2));
      run(2);
      check("jal_x1", xr(1), 32'd4);
      check("jal_skip_x2", xr(2), 32'd0);
      check("jal_x3", xr(3), 32'd2);
      check("jal_pc", dut.PC, 32'd12);

      // ---- jalr, including rd == rs1 and bit-0 clearing ----
      start_prog();
      put(0, addi(5'd6, 5'd0, 12'd12));
      put(1, i_t(12'd0, 5'd6, 3'd0, 5'd5, O_JALR));
      put(2, addi(5'd2, 5'd0, 12'd1));
      put(3, addi(5'd3, 5'd0, 12'd3));
      put(4, addi(5'd7, 5'd0, 12'd29));
      put(5, i_t(12'd0, 5'd7, 3'd0, 5'd7, O_JALR));
      put(6, addi(5'd9, 5'd0, 12'd1));
      put(7, addi(5'd8, 5'd0, 12'd9));
      run(6);
      check("jalr_x5", xr(5), 32'd8);
      check("jalr_skip_x2", xr(2), 32'd0);
      check("jalr_x3", xr(3), 32'd3);
      check("jalr_same_x7", xr(7), 32'd24);
      check("jalr_skip_x9", xr(9), 32'd0);
      check("jalr_x8", xr(8), 32'd9);
      check("jalr_pc", dut.PC, 32'd32);

      // ---- lui / auipc ----
      start_prog();
      put(0, u_t(20'h00001, 5'd3, O_AUIPC));
      put(1, u_t(20'h12345, 5'd1, O_LUI));
      put(2, u_t(20'hFFFFF, 5'd2, O_LUI));
      put(3, u_t(20'h00002, 5'd4, O_AUIPC));
      run(4);
      check("lui_x1", xr(1), 32'h1234_5000);
      check("lui_x2", xr(2), 32'hFFFF_F000);
      check("auipc_x3", xr(3), 32'h0000_1000);
      check("auipc_x4", xr(4), 32'h0000_200C);

      // ---- x0, illegal opcodes, mid-run reset ----
      start_prog();
      put(0, addi(5'd0, 5'd0, 12'd7));
      put(1, addi(5'd1, 5'd0, 12'd7));
      put(2, r_t(7'h00, 5'd1, 5'd0, 3'd0, 5'd2));
      put(3, 32'hFFFF_FFFF);
      put(5, addi(5'd10, 5'd1, 12'd1));
      run(6);
      check("x0_zero", xr(0), 32'h0);
      check("x0_read_x2", xr(2), 32'd7);
      check("illegal_x31", xr(31), 32'h0);
      check("after_nop_x10", xr(10), 32'd8);
      check("nop_run_pc", dut.PC, 32'd24);
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      check("midrst_pc", dut.PC, 32'h0);
      for (int i = 0; i < 32; i++) check($sformatf("midrst_x%0d", i), xr(i), 32'h0);
      // Store of x0 to word 0 sits at PC 0 while reset is held.
      put(0, s_t(12'd0, 5'd0, 5'd0));
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_store_dm0", dm(0), 32'd100);
      check("rst_keeps_dm1", dm(1), 32'hFFFF_FFFF);
      check("rst_hold_pc", dut.PC, 32'h0);
      run(1);
      check("first_edge_store", dm(0), 32'h0);
      check("first_edge_pc", dut.PC, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have no parameters; instruction memory depth fixed at 256 words, data memory depth fixed at 256 words.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have no other ports; program/data are visible only through internal hierarchy (REQ-020).

Function
REQ-005 SHALL be a single-cycle RV32I core: one instruction fetched, executed and retired per rising clk edge.
REQ-006 SHALL hold a 32-bit program counter signal PC; instr SHALL be the 32-bit word combinationally read from instruction_memory[PC[9:2]].
REQ-007 SHALL execute R-type add, sub, and, or, xor, sll, srl, sra, slt, sltu.
REQ-008 SHALL execute I-type addi, andi, ori, xori, slti, sltiu, slli, srli, srai; immediates are sign-extended 12-bit.
REQ-009 SHALL execute lw (rd = data_memory[(rs1+imm)[9:2]]) and sw (data_memory[(rs1+imm)[9:2]] = rs2 at the edge); byte/halfword loads/stores are not supported.
REQ-010 SHALL execute beq, bne, blt, bge, bltu, bgeu: taken -> PC = PC + sext(B-imm); not taken -> PC + 4.
REQ-011 SHALL execute jal: rd = PC + 4, PC = PC + sext(J-imm).
REQ-012 SHALL execute jalr: rd = PC + 4, PC = (rs1 + sext(imm)) & ~1; rs1 read before rd write (rd == rs1 safe).
REQ-013 SHALL execute lui: rd = {imm[31:12], 12'b0}; auipc: rd = PC + {imm[31:12], 12'b0}.
REQ-014 All other PCs advance by 4; arithmetic wraps modulo 2^32; shift amount uses low 5 bits.
REQ-015 Writes to x0 SHALL be discarded; x0 always reads 0.
REQ-016 Register file: 32 x 32-bit, two combinational read ports, one write port at rising edge; a read of the register being written returns the old value.
REQ-017 Unrecognised opcodes (including all-zero word) SHALL act as NOP: no register/memory write, PC + 4.
REQ-018 PC SHALL wrap modulo 2^32; instruction/data addresses use only bits [9:2] (aliasing beyond 1 KiB, low bits ignored).
REQ-019 Data memory: combinational read, synchronous write; write and read of the same word in one cycle returns the old value.
REQ-020 Hierarchy SHALL expose: DUT_instr.instruction_memory[0:255] (32-bit words, loadable by $readmemh), DUT_RF.RF[0:31], DUT_Data.data_memory[0:255], and top-level signals PC and instr.

Reset
REQ-021 n_rst low SHALL asynchronously clear PC to 0x00000000 and all RF entries to 0.
REQ-022 Reset SHALL NOT clear instruction_memory or data_memory; contents loaded or written during/after reset are preserved.
REQ-023 While n_rst is low no register or data memory write SHALL occur; first instruction executes at the first rising edge after deassertion.
REQ-024 Reset asserted mid-program SHALL abort execution immediately; PC restarts at 0.

Structure
REQ-025 Opcode, funct3/funct7 and ALU-operation constants/enum SHALL reside in a shared package (rv32i_pkg).
REQ-026 Sub-modules: instruction memory (instance DUT_instr), register file (instance DUT_RF), data memory (instance DUT_Data); decoder, immediate generator and ALU as combinational logic in top or one alu sub-module.

Verification
REQ-027 addi x1,x0,10; addi x2,x0,5; add x3,x1,x2; sub x4,x1,x2 from reset, 7 edges -> x1=10, x2=5, x3=15, x4=5.
REQ-028 addi x1,x0,100; sw x1,0(x0); lw x2,0(x0); addi x3,x2,1 -> data_memory[0]=100, x2=100, x3=101.
REQ-029 addi x1,x0,0; addi x2,x0,5; loop: addi x1,x1,1; bne x1,x2,loop; 19 edges -> x1=5.
REQ-030 jal x1 at PC 0 skipping addi x2,x0,1 to addi x3,x0,2 -> x1=4, x2=0, x3=2; jalr x5 at PC 4 -> x5=8, skipped instr leaves x2=0.
REQ-031 lui x1,0x12345; lui x2,0xFFFFF -> x1=0x12345000, x2=0xFFFFF000; auipc x3,1 at PC 0 -> 0x00001000; auipc x4,2 at PC 0xC -> 0x0000200C.
REQ-032 addi x0,x0,7 then reset mid-run -> x0 reads 0 throughout; after reset PC=0 and all RF entries 0.
